// File: rtl/fifo_dc_wr_arbiter.sv
// fifo_dc_wr_arbiter: round-robin, packet-locked arbiter sharing one dual-clock FIFO write port among N_REQ requesters
module fifo_dc_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS = 16,
  localparam int ID_WIDTH = $clog2(N_REQ),
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                          clk_w,
  input  logic                          rst_w,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_write,
  output logic [DATA_WIDTH+ID_WIDTH:0]  fifo_data,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           gnt_id,
  output logic                          overrun,
  input  logic                          clr_overrun
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] gnt_q, gnt_d, rr_q, rr_d, pick;
  logic [CW-1:0] beat_q, beat_d;
  logic overrun_q, overrun_d, accept, forced, last_out;
  logic [DATA_WIDTH-1:0] data_sel;
  int off, best;
  // Lowest distance from rr_q+1 (mod N_REQ) wins the grant.
  always_comb begin
    pick = '0;
    best = N_REQ;
    off = 0;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + N_REQ - 1 - int'(rr_q)) % N_REQ;
      if (req_valid[i] && off < best) begin
        best = off;
        pick = ID_WIDTH'(i);
      end
    end
  end
  assign busy = state_q == BUSY;
  assign gnt_id = gnt_q;
  assign overrun = overrun_q;
  assign data_sel = DATA_WIDTH'(req_data >> (int'(gnt_q) * DATA_WIDTH));
  assign forced = beat_q == CW'(MAX_BEATS - 1);
  assign last_out = req_last[gnt_q] || forced;
  assign accept = busy && req_valid[gnt_q] && !fifo_full;
  assign req_ready = (busy && !fifo_full) ? N_REQ'(1) << gnt_q : '0;
  assign fifo_write = accept;
  assign fifo_data = {gnt_q, last_out, data_sel};
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    beat_d = beat_q;
    if (state_q == IDLE && en && |req_valid) begin
      state_d = BUSY;
      gnt_d = pick;
      rr_d = pick;
      beat_d = '0;
    end
    if (accept) begin
      beat_d = beat_q + CW'(1);
      state_d = last_out ? IDLE : state_q;
    end
    overrun_d = (accept && forced && !req_last[gnt_q]) ? 1'b1 : clr_overrun ? 1'b0 : overrun_q;
  end
  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= ID_WIDTH'(N_REQ - 1);
      beat_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      beat_q <= beat_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_fifo_dc_wr_arbiter.sv
// tb_fifo_dc_wr_arbiter: directed scenarios with literal expectations plus randomized traffic checked against a packet-level model
module tb_fifo_dc_wr_arbiter;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int MB = 4;
  logic clk_w = 1'b0, rst_w = 1'b1, en = 1'b1, fifo_full = 1'b0, clr_overrun = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic fifo_write, busy, overrun;
  logic [DW+2:0] fifo_data;
  logic [1:0] gnt_id;
  int tests = 0, fails = 0;
  int m_owner = -1, m_last = N - 1, m_beats = 0;
  logic [1:0] m_gid = '0;
  logic m_ovr = 1'b0;

  fifo_dc_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk_w(clk_w), .rst_w(rst_w), .en(en), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .fifo_full(fifo_full), .busy(busy), .gnt_id(gnt_id), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk_w = ~clk_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk_w);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_w);
    #1;
  endtask

  task automatic setd(input int i, input logic [DW-1:0] d);
    req_data = (req_data & ~({{(N*DW-DW){1'b0}}, {DW{1'b1}}} << (i * DW))) | ((N*DW)'(d) << (i * DW));
  endtask

  task automatic do_reset();
    rst_w = 1'b1;
    req_valid = '0;
    req_last = '0;
    en = 1'b1;
    fifo_full = 1'b0;
    clr_overrun = 1'b0;
    nxt();
    nxt();
    rst_w = 1'b0;
  endtask

  // Packet-level model: who owns the port, how many beats it has sent, who won last.
  always @(negedge clk_w) begin
    logic [1:0] ow;
    logic e_wr, e_lb, e_forced, set;
    logic [DW+2:0] e_data;
    if (rst_w) begin
      m_owner = -1;
      m_last = N - 1;
      m_beats = 0;
      m_gid = '0;
      m_ovr = 1'b0;
      chk("m_rst_busy", busy, 0);
      chk("m_rst_write", fifo_write, 0);
      chk("m_rst_ready", req_ready, 0);
      chk("m_rst_overrun", overrun, 0);
      chk("m_rst_gnt", gnt_id, 0);
    end else begin
      ow = m_owner[1:0];
      e_forced = m_beats == MB - 1;
      e_lb = req_last[ow] || e_forced;
      e_wr = m_owner >= 0 && req_valid[ow] && !fifo_full;
      e_data = {ow, e_lb, DW'(req_data >> (m_owner * DW))};
      chk("m_busy", busy, m_owner >= 0);
      chk("m_gnt", gnt_id, m_gid);
      chk("m_ready", req_ready, (m_owner >= 0 && !fifo_full) ? (4'b1 << ow) : 4'b0);
      chk("m_write", fifo_write, e_wr);
      chk("m_overrun", overrun, m_ovr);
      if (e_wr) chk("m_data", fifo_data, e_data);
      set = e_wr && e_forced && !req_last[ow];
      if (m_owner < 0) begin
        if (en && |req_valid) begin
          for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              break;
            end
          end
          m_last = m_owner;
          m_gid = m_owner[1:0];
          m_beats = 0;
        end
      end else if (e_wr) begin
        m_beats++;
        if (e_lb) m_owner = -1;
      end
      m_ovr = set ? 1'b1 : clr_overrun ? 1'b0 : m_ovr;
    end
  end

  initial begin
    mid();
    chk("reset_busy", busy, 0);
    chk("reset_gnt", gnt_id, 0);
    chk("reset_write", fifo_write, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_overrun", overrun, 0);
    // 3-beat packet from requester 0
    do_reset();
    req_valid = 4'b0001;
    setd(0, 16'hA);
    mid(); chk("t1_idle_busy", busy, 0); chk("t1_idle_write", fifo_write, 0);
    nxt(); mid(); chk("t1_busy", busy, 1); chk("t1_ready", req_ready, 4'b0001); chk("t1_d0", fifo_data, 19'h0000A);
    nxt(); setd(0, 16'hB); mid(); chk("t1_d1", fifo_data, 19'h0000B);
    nxt(); setd(0, 16'hC); req_last = 4'b0001; mid(); chk("t1_d2", fifo_data, 19'h1000C);
    nxt(); req_valid = '0; req_last = '0; mid(); chk("t1_after_busy", busy, 0); chk("t1_after_write", fifo_write, 0);
    // four 1-beat requesters: round robin, one write every two cycles
    do_reset();
    req_valid = 4'hF;
    req_last = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      mid();
      chk("t2_cadence", fifo_write, c % 2 == 0);
      if (c % 2 == 0) chk("t2_order", gnt_id, ((c / 2) - 1) % 4);
      nxt();
    end
    // FIFO full stall mid-packet
    do_reset();
    req_valid = 4'b0100;
    setd(2, 16'h2222);
    mid(); nxt(); mid(); chk("t3_first_write", fifo_write, 1); chk("t3_gnt", gnt_id, 2);
    nxt(); fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid(); chk("t3_full_ready", req_ready, 0); chk("t3_full_write", fifo_write, 0); chk("t3_full_gnt", gnt_id, 2);
      nxt();
    end
    fifo_full = 1'b0; req_last = 4'b0100;
    mid(); chk("t3_resume_write", fifo_write, 1); chk("t3_resume_data", fifo_data, 19'h52222);
    nxt(); req_valid = '0; req_last = '0; mid(); chk("t3_done", busy, 0);
    // runaway packet from requester 1 truncated at MAX_BEATS, requester 3 waiting
    do_reset();
    req_valid = 4'b1010;
    req_last = 4'b1000;
    setd(1, 16'h1111);
    setd(3, 16'h3333);
    mid(); chk("t4_idle", busy, 0); nxt();
    for (int c = 2; c <= 5; c++) begin
      mid(); chk("t4_write", fifo_write, 1); chk("t4_gnt", gnt_id, 1); chk("t4_last", fifo_data[16], c == 5);
      nxt();
    end
    mid(); chk("t4_bubble", busy, 0); chk("t4_overrun", overrun, 1); nxt();
    mid(); chk("t4_gnt3", gnt_id, 3); chk("t4_d3", fifo_data, 19'h73333); nxt();
    mid(); chk("t4_bubble2", busy, 0); nxt();
    mid(); chk("t4_regnt1", gnt_id, 1); chk("t4_b5_write", fifo_write, 1); chk("t4_b5_last", fifo_data[16], 0);
    nxt(); req_last = 4'b1010;
    mid(); chk("t4_b6_last", fifo_data[16], 1);
    nxt(); req_valid = '0; req_last = '0; clr_overrun = 1'b1;
    mid(); chk("t4_ovr_held", overrun, 1);
    nxt(); clr_overrun = 1'b0;
    mid(); chk("t4_ovr_clr", overrun, 0);
    // en dropped mid-packet: packet finishes, no new grant until en returns
    do_reset();
    req_valid = 4'b0001;
    mid(); nxt();
    mid(); chk("t5_b1", fifo_write, 1); nxt();
    en = 1'b0; req_valid = 4'b0101;
    mid(); chk("t5_b2", fifo_write, 1); nxt();
    mid(); chk("t5_b3", fifo_write, 1); nxt();
    req_last = 4'b0001;
    mid(); chk("t5_b4", fifo_write, 1); chk("t5_b4_last", fifo_data[16], 1); nxt();
    req_last = '0;
    for (int c = 0; c < 4; c++) begin
      mid(); chk("t5_hold_busy", busy, 0); chk("t5_hold_write", fifo_write, 0); nxt();
    end
    en = 1'b1;
    mid(); chk("t5_latency", busy, 0); nxt();
    mid(); chk("t5_resume_busy", busy, 1); chk("t5_resume_gnt", gnt_id, 2); nxt();
    // asynchronous reset on beat 2
    do_reset();
    req_valid = 4'b0001;
    mid(); nxt();
    mid(); nxt();
    mid(); chk("t6_beat2", fifo_write, 1);
    rst_w = 1'b1;
    #1;
    chk("t6_async_write", fifo_write, 0); chk("t6_async_ready", req_ready, 0); chk("t6_async_busy", busy, 0);
    nxt(); nxt();
    rst_w = 1'b0; req_valid = 4'b1010;
    mid(); chk("t6_idle", busy, 0); nxt();
    mid(); chk("t6_gnt1", gnt_id, 1); chk("t6_busy", busy, 1); nxt();
    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_last[i] = $urandom_range(0, 4) == 0;
      req_data = {$urandom, $urandom};
      fifo_full = $urandom_range(0, 3) == 0;
      en = $urandom_range(0, 7) != 0;
      clr_overrun = $urandom_range(0, 15) == 0;
      rst_w = $urandom_range(0, 499) == 0;
      nxt();
    end
    rst_w = 1'b0;
    mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
